// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register-file write port between write-back (priority) and a FIFO'd
// loader port, with a starvation guard. Optional macro LD_BYPASS_EN enables a 1-cycle loader bypass.
module reg_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_valid,
  input  logic [7:0]                  wb_data,
  input  logic [2:0]                  wb_reg,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [7:0]                  ld_data,
  input  logic [2:0]                  ld_reg,
  output logic                        rf_we,
  output logic [2:0]                  rf_addr,
  output logic [7:0]                  rf_data,
  output logic                        stall_req,
  output logic [$clog2(FIFO_DEPTH):0] ld_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StNormal, StStall} state_e;

  logic [7:0]      mem_data_q [FIFO_DEPTH];
  logic [2:0]      mem_reg_q  [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [2:0]      rf_addr_q, rf_addr_d;
  logic [7:0]      rf_data_q, rf_data_d;
  state_e          state_q, state_d;
  logic            stall_req_q, stall_req_d;

  logic full, empty, push, pop, bypass;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

`ifdef LD_BYPASS_EN
  // An idle port lets a loader transfer go straight to the rf registers.
  assign bypass = ld_valid && !full && empty && !wb_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = ld_valid && !full && !bypass;
  assign pop  = !wb_valid && !empty;

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= ld_data;
      mem_reg_q[wr_ptr_q]  <= ld_reg;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_valid) begin
      rf_we_d   = 1'b1;
      rf_addr_d = wb_reg;
      rf_data_d = wb_data;
    end else if (!empty) begin
      rf_we_d   = 1'b1;
      rf_addr_d = mem_reg_q[rd_ptr_q];
      rf_data_d = mem_data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d   = 1'b1;
      rf_addr_d = ld_reg;
      rf_data_d = ld_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // FSM state register; stall_req trails the state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StNormal;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_req_q <= stall_req_d;
    end
  end

  // Decisions use next-state counter/occupancy so transitions land on the edge the condition forms.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: if (starve_d >= 8'(STARVE_LIMIT)) state_d = StStall;
      StStall:  if (count_d == '0) state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  always_comb begin
    stall_req_d = (state_q == StStall);
  end

  assign ld_ready  = !full;
  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign stall_req = stall_req_q;
  assign ld_count  = count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter at default parameters (no LD_BYPASS_EN).
module tb_reg_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_valid, ld_valid, ld_ready;
  logic [7:0] wb_data, ld_data, rf_data;
  logic [2:0] wb_reg, ld_reg, rf_addr;
  logic       rf_we, stall_req;
  logic [2:0] ld_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_write_arbiter #(
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_reg   (wb_reg),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_reg   (ld_reg),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .stall_req(stall_req),
    .ld_count (ld_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [2:0] a,
                          input logic [7:0] d);
    check({tag, "_we"}, 32'(rf_we), 32'(we));
    check({tag, "_addr"}, 32'(rf_addr), 32'(a));
    check({tag, "_data"}, 32'(rf_data), 32'(d));
  endtask

  logic [2:0] exp_reg [6];
  logic [7:0] exp_dat [6];

  initial begin
    reset = 1'b0;
    wb_valid = 1'b0; wb_data = '0; wb_reg = '0;
    ld_valid = 1'b0; ld_data = '0; ld_reg = '0;
    #2;
    check_rf("rst", 1'b0, 3'd0, 8'h00);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_count", 32'(ld_count), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd1);
    step();
    step();
    reset = 1'b1;

    // Write-back priority over a simultaneous loader request.
    wb_valid = 1'b1; wb_reg = 3'd5; wb_data = 8'hA7;
    ld_valid = 1'b1; ld_reg = 3'd2; ld_data = 8'h11;
    step();
    check_rf("prio_wb", 1'b1, 3'd5, 8'hA7);
    check("prio_count", 32'(ld_count), 32'd1);
    wb_valid = 1'b0; ld_valid = 1'b0;
    step();
    check_rf("prio_ld", 1'b1, 3'd2, 8'h11);
    check("prio_count0", 32'(ld_count), 32'd0);
    step();
    check_rf("prio_idle", 1'b0, 3'd2, 8'h11);

    // FIFO full under continuous write-back.
    wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 8'h50;
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_reg = 3'(i + 3); ld_data = 8'h20 + 8'(i);
      check($sformatf("full_ready%0d", i), 32'(ld_ready), 32'd1);
      step();
      check($sformatf("full_count%0d", i), 32'(ld_count), 32'(i + 1));
    end
    ld_reg = 3'd7; ld_data = 8'h24;
    check("full_ready_blk", 32'(ld_ready), 32'd0);
    step();
    check("full_count_hold", 32'(ld_count), 32'd4);
    check_rf("full_wb", 1'b1, 3'd1, 8'h50);
    check("full_nostall", 32'(stall_req), 32'd0);
    wb_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_rf($sformatf("full_pop%0d", i), 1'b1, 3'(i + 3), 8'h20 + 8'(i));
      check($sformatf("full_pcount%0d", i), 32'(ld_count), 32'(3 - i));
    end
    step();
    check_rf("full_drained", 1'b0, 3'd6, 8'h23);

    // Starvation: one entry stuck behind continuous write-back.
    wb_valid = 1'b1; wb_reg = 3'd0; wb_data = 8'h33;
    ld_valid = 1'b1; ld_reg = 3'd1; ld_data = 8'h44;
    step();
    ld_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("starve_k%0d", k), 32'(stall_req), (k >= 9) ? 32'd1 : 32'd0);
    end
    check_rf("starve_wb", 1'b1, 3'd0, 8'h33);
    check("starve_count", 32'(ld_count), 32'd1);
    wb_valid = 1'b0;
    step();
    check_rf("starve_pop", 1'b1, 3'd1, 8'h44);
    check("starve_empty", 32'(ld_count), 32'd0);
    check("starve_still", 32'(stall_req), 32'd1);
    step();
    check("starve_fall", 32'(stall_req), 32'd0);

    // Simultaneous push/pop at occupancy 2, across pointer wrap.
    for (int i = 0; i < 6; i++) begin
      exp_reg[i] = 3'(i + 2);
      exp_dat[i] = 8'h61 + 8'(i);
    end
    wb_valid = 1'b1; wb_reg = 3'd0; wb_data = 8'h00;
    ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ld_reg = exp_reg[i]; ld_data = exp_dat[i];
      step();
    end
    check("pp_count_init", 32'(ld_count), 32'd2);
    wb_valid = 1'b0;
    for (int i = 2; i < 6; i++) begin
      ld_reg = exp_reg[i]; ld_data = exp_dat[i];
      step();
      check_rf($sformatf("pp_issue%0d", i - 2), 1'b1, exp_reg[i-2], exp_dat[i-2]);
      check($sformatf("pp_count%0d", i - 2), 32'(ld_count), 32'd2);
    end
    ld_valid = 1'b0;
    for (int i = 4; i < 6; i++) begin
      step();
      check_rf($sformatf("pp_drain%0d", i), 1'b1, exp_reg[i], exp_dat[i]);
    end
    check("pp_count_end", 32'(ld_count), 32'd0);

    // Reset mid-stream with three queued entries.
    wb_valid = 1'b1; wb_reg = 3'd4; wb_data = 8'h9C;
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_reg = 3'(i + 1); ld_data = 8'hB0 + 8'(i);
      step();
    end
    check("mrst_pre_count", 32'(ld_count), 32'd3);
    reset = 1'b0;
    wb_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check_rf("mrst", 1'b0, 3'd0, 8'h00);
    check("mrst_count", 32'(ld_count), 32'd0);
    check("mrst_ready", 32'(ld_ready), 32'd1);
    check("mrst_stall", 32'(stall_req), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mrst_nowe%0d", i), 32'(rf_we), 32'd0);
      check($sformatf("mrst_cnt%0d", i), 32'(ld_count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
